// File: rtl/pong_pio_pkg.sv
// ----------------------------------------------------------------------------
// pong_pio_pkg : register offsets and pulse-count width for pong_led_pio
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pong_pio_pkg;

  localparam int COUNT_W = 24;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_OUTSET   = 2'd1;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE    = 2'd3;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/pio_pulse_timer.sv
// ----------------------------------------------------------------------------
// pio_pulse_timer : loadable down-counter that saturates at zero
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pio_pulse_timer
  import pong_pio_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  count_t load_count,
  output count_t count,
  output logic   active
);

  // A load always wins over the decrement so a new pulse restarts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_count;
    end else if (count != '0) begin
      count <= count - count_t'(1);
    end
  end

  assign active = (count != '0);

endmodule

`default_nettype wire

// File: rtl/pong_led_pio.sv
// ----------------------------------------------------------------------------
// pong_led_pio : Avalon-MM output PIO with set/clear/timed-pulse registers
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pong_led_pio
  import pong_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_active
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] mask_reg;
  count_t           count_reg;
  logic             wr_en;
  logic             pulse_load;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      mask_ext;
  logic [31:0]      rd_next;

  assign wr_en      = chipselect & ~write_n;
  assign wr_bits    = writedata[WIDTH-1:0];
  assign pulse_load = wr_en && (address == ADDR_PULSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
      mask_reg <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_reg <= wr_bits;
        ADDR_OUTSET:   data_reg <= data_reg | wr_bits;
        ADDR_OUTCLEAR: data_reg <= data_reg & ~wr_bits;
        default:       mask_reg <= wr_bits;
      endcase
    end
  end

  pio_pulse_timer u_pulse_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (pulse_load),
    .load_count (writedata[31:32-COUNT_W]),
    .count      (count_reg),
    .active     (pulse_active)
  );

  // Read mux uses pre-write register values, so a write shows up a cycle later.
  assign mask_ext = 32'(mask_reg);

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:  rd_next = 32'(data_reg);
      ADDR_PULSE: rd_next = {count_reg, mask_ext[7:0]};
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign out_port = data_reg ^ (mask_reg & {WIDTH{pulse_active}});

endmodule

`default_nettype wire
